// File: rtl/axis_stall_monitor_pkg.sv
// Shared types and helpers for the per-kernel AXI-Stream stall monitor.
package axis_stall_monitor_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PENDING  = 2'd2,
    ST_BLOCKED  = 2'd3
  } mon_state_t;

  localparam int MIN_THRESHOLD = 2;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
    lowest_set_idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = i;
    end
  endfunction

endpackage

// File: rtl/stall_prio_enc.sv
// Combinational lowest-set-bit encoder for the blocked-port pattern.
module stall_prio_enc
  import axis_stall_monitor_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx
);

  assign idx = IDX_W'(lowest_set_idx(32'(vec)));

endmodule

// File: rtl/axis_stall_monitor.sv
// Declares a kernel stall when a non-empty block pattern holds unchanged for
// thr_eff cycles, and latches which streams were blocked at that moment.
module axis_stall_monitor
  import axis_stall_monitor_pkg::*;
#(
  parameter int N_AXIS = 4,
  parameter int N_INST = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  threshold,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic              block_pulse,
  output logic [N_AXIS-1:0] block_cause,
  output logic [IDX_W-1:0]  first_idx,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int PAT_W = N_AXIS + N_INST;

  mon_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PAT_W-1:0]  prev_pattern, prev_n;
  logic [CNT_W-1:0]  stall_n;
  logic              block_n, pulse_n;
  logic [N_AXIS-1:0] cause_n;
  logic [IDX_W-1:0]  idx_n, enc_idx;

  logic              stall_cond;
  logic [PAT_W-1:0]  pattern;
  logic [CNT_W-1:0]  thr_eff;

  assign stall_cond = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  assign pattern    = {axis_block_sigs, inst_block_sigs};
  assign thr_eff    = (threshold < CNT_W'(MIN_THRESHOLD)) ? CNT_W'(MIN_THRESHOLD) : threshold;

  stall_prio_enc #(.N(N_AXIS), .IDX_W(IDX_W)) u_prio_enc (
    .vec (axis_block_sigs),
    .idx (enc_idx)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    prev_n  = prev_pattern;
    stall_n = stall_cycles;
    block_n = block;
    pulse_n = 1'b0;
    cause_n = block_cause;
    idx_n   = first_idx;

    if (!enable || clear || state == ST_DISARMED) begin
      // disable, clear and the arming edge all land on a zeroed datapath
      state_n = enable ? ST_ARMED : ST_DISARMED;
      cnt_n   = '0;
      prev_n  = '0;
      stall_n = '0;
      block_n = 1'b0;
      cause_n = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        ST_ARMED: begin
          if (stall_cond) begin
            state_n = ST_PENDING;
            cnt_n   = CNT_W'(1);
            prev_n  = pattern;
          end
        end
        ST_PENDING: begin
          if (!stall_cond) begin
            state_n = ST_ARMED;
            cnt_n   = '0;
          end else if (pattern != prev_pattern) begin
            // a changed pattern means the kernel made progress
            cnt_n  = CNT_W'(1);
            prev_n = pattern;
          end else if (cnt >= thr_eff - CNT_W'(1)) begin
            state_n = ST_BLOCKED;
            block_n = 1'b1;
            pulse_n = 1'b1;
            stall_n = CNT_W'(1);
            cause_n = axis_block_sigs;
            idx_n   = enc_idx;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_BLOCKED: begin
          if (stall_cycles != '1) stall_n = stall_cycles + CNT_W'(1);
        end
        default: state_n = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      state        <= ST_DISARMED;
      cnt          <= '0;
      prev_pattern <= '0;
      stall_cycles <= '0;
      block        <= 1'b0;
      block_pulse  <= 1'b0;
      block_cause  <= '0;
      first_idx    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_n;
      cnt          <= cnt_n;
      prev_pattern <= prev_n;
      stall_cycles <= stall_n;
      block        <= block_n;
      block_pulse  <= pulse_n;
      block_cause  <= cause_n;
      first_idx    <= idx_n;
    end
  end

endmodule
